multicycle_main_control: RTL and testbench

Main control FSM for the multi-cycle RV32 subset datapath (R-type ALU, I-type ALU, lw, sw, beq). It sequences the shared ALU, register file, instruction register, PC and unified memory over several cycles per instruction. It drives the 2-bit ALUOp consumed by the ALU control decoder and implements a request/ready handshake to memory. It also keeps a retired-instruction counter.

---
 rtl/multicycle_main_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_main_control.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32 subset datapath (R/I ALU, lw, sw, beq).
// Optional feature macro MEM_WAIT_EN: memory accesses stall until mem_ready.
module multicycle_main_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_q, state_d;
  logic   illegal_d;
  logic   retire;
  logic   mem_done;

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    illegal_d   = 1'b0;
    retire      = 1'b0;
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
          OP_LOAD, OP_STORE:  state_d = S_MEMADR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_done) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        ALUSrcB = (opcode == OP_RTYPE) ? 2'b00 : 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset drops any pending access and blocks all architectural writes at once.
    if (reset) begin
      mem_req     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (reset) begin
      state_q <= S_FETCH;
      instret <= 32'd0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal <= illegal_d;
      if (retire) instret <= instret + 32'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed self-checking bench for multicycle_main_control; follows MEM_WAIT_EN if defined.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource;
  logic        ALUSrcA, RegWrite, MemtoReg, illegal;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [31:0] instret;
  logic [6:0]  en;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // Write/request enables that reset must force low.
  assign en = {mem_req, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = OP_R;
    mem_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check("rst_enables", 32'(en), 32'd0);
    end
    check("rst_state", 32'(state), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // R-type: 0,1,6,7,0
    reset = 1'b0;
    #1;
    check("r_fetch_state", 32'(state), 32'd0);
    check("r_fetch_en", 32'(en), 32'b1101100);
    check("r_fetch_alu", 32'({ALUSrcA, ALUSrcB, ALUOp, IorD}), 32'b0_01_00_0);
    next();
    check("r_decode_state", 32'(state), 32'd1);
    check("r_decode_srcb", 32'(ALUSrcB), 32'b11);
    next();
    check("r_exec_state", 32'(state), 32'd6);
    check("r_exec_alu", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b1_00_10);
    next();
    check("r_aluwb_state", 32'(state), 32'd7);
    check("r_aluwb_wb", 32'({RegWrite, MemtoReg}), 32'b10);
    next();
    check("r_done_state", 32'(state), 32'd0);
    check("r_instret", instret, 32'd1);

    // lw: 0,1,2,3[,3,3],4,0
    opcode = OP_LW;
    next();
    check("lw_decode_state", 32'(state), 32'd1);
    next();
    check("lw_memadr_state", 32'(state), 32'd2);
    check("lw_memadr_alu", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b1_10_00);
    next();
    check("lw_memrd_state", 32'(state), 32'd3);
    check("lw_memrd_bus", 32'({mem_req, MemRead, MemWrite, IorD}), 32'b1101);
`ifdef MEM_WAIT_EN
    mem_ready = 1'b0;
    next();
    check("lw_wait1_state", 32'(state), 32'd3);
    check("lw_wait1_bus", 32'({mem_req, MemRead, MemWrite, IorD}), 32'b1101);
    next();
    check("lw_wait2_state", 32'(state), 32'd3);
    mem_ready = 1'b1;
`endif
    next();
    check("lw_memwb_state", 32'(state), 32'd4);
    check("lw_memwb_wb", 32'({RegWrite, MemtoReg}), 32'b11);
    next();
    check("lw_done_state", 32'(state), 32'd0);
    check("lw_instret", instret, 32'd2);

    // sw then beq back-to-back
    opcode = OP_SW;
    next();
    check("sw_decode_state", 32'(state), 32'd1);
    next();
    check("sw_memadr_state", 32'(state), 32'd2);
    next();
    check("sw_memwr_state", 32'(state), 32'd5);
    check("sw_memwr_bus", 32'({mem_req, MemRead, MemWrite, IorD}), 32'b1011);
    opcode = OP_BEQ;
    next();
    check("sw_done_state", 32'(state), 32'd0);
    check("sw_instret", instret, 32'd3);
    next();
    check("beq_decode_state", 32'(state), 32'd1);
    next();
    check("beq_branch_state", 32'(state), 32'd8);
    check("beq_branch_ctl", 32'({ALUOp, PCWriteCond, PCSource, ALUSrcA, ALUSrcB}), 32'b01_1_1_1_00);
    check("beq_no_wb", 32'({RegWrite, PCWrite}), 32'b00);
    next();
    check("beq_done_state", 32'(state), 32'd0);
    check("beq_instret", instret, 32'd4);

`ifdef MEM_WAIT_EN
    mem_ready = 1'b0;
    #1;
    check("fetch_stall_wr", 32'({IRWrite, PCWrite}), 32'b00);
    next();
    check("fetch_stall_state", 32'(state), 32'd0);
    mem_ready = 1'b1;
    #1;
`endif

    // Illegal opcode: 0,1,0 with a one-cycle illegal pulse
    opcode = OP_BAD;
    next();
    check("bad_decode_state", 32'(state), 32'd1);
    check("bad_decode_illegal", 32'(illegal), 32'd0);
    next();
    check("bad_back_state", 32'(state), 32'd0);
    check("bad_illegal_pulse", 32'(illegal), 32'd1);
    check("bad_instret", instret, 32'd4);
    opcode = OP_I;
    next();
    check("addi_decode_state", 32'(state), 32'd1);
    check("bad_illegal_clear", 32'(illegal), 32'd0);
    next();
    check("addi_exec_state", 32'(state), 32'd6);
    check("addi_exec_alu", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b1_10_10);
    next();
    check("addi_aluwb_state", 32'(state), 32'd7);
    next();
    check("addi_instret", instret, 32'd5);

    // Reset while in MEMRD abandons the load
    opcode = OP_LW;
    next();
    next();
    next();
    check("rmid_memrd_state", 32'(state), 32'd3);
    mem_ready = 1'b0;
    #1;
    check("rmid_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rmid_enables", 32'(en), 32'd0);
    next();
    check("rmid_state", 32'(state), 32'd0);
    check("rmid_instret", instret, 32'd0);
    check("rmid_enables2", 32'(en), 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_I;
    #1;

    // Counter wrap from all-ones
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    check("wrap_preload", instret, 32'hFFFF_FFFF);
    next();
    next();
    next();
    check("wrap_aluwb_state", 32'(state), 32'd7);
    check("wrap_hold", instret, 32'hFFFF_FFFF);
    next();
    check("wrap_state", 32'(state), 32'd0);
    check("wrap_instret", instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
